// File: rtl/multi_input_conditioner.sv
// Multi-channel pin conditioner: per-channel synchroniser, stability-window debouncer,
// registered edge pulses, and a masked sticky edge-capture register.
module multi_input_conditioner #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] edge_mask,
  input  logic [CHANNELS-1:0] clear_seen,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] edge_seen,
  output logic                any_edge
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_cond;
    logic                   r_pos;
    logic                   r_neg;
    logic                   r_seen;
    logic                   w_sync_last;
    logic                   w_mismatch;
    logic                   w_accept;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_mismatch  = (w_sync_last != r_cond);
    assign w_accept    = w_mismatch && (r_cnt == CNT_LAST);

    // Only the last synchroniser stage is ever observed.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], noisysignal[c]};
      end
    end

    // A new level is accepted after WAIT_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt  <= '0;
        r_cond <= 1'b0;
        r_pos  <= 1'b0;
        r_neg  <= 1'b0;
      end else begin
        r_pos <= w_accept && w_sync_last;
        r_neg <= w_accept && !w_sync_last;
        if (w_accept) begin
          r_cond <= w_sync_last;
        end
        if (!w_mismatch || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    // Sticky capture; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_seen <= 1'b0;
      end else if ((r_pos || r_neg) && edge_mask[c]) begin
        r_seen <= 1'b1;
      end else if (clear_seen[c]) begin
        r_seen <= 1'b0;
      end
    end

    assign conditioned[c]  = r_cond;
    assign positiveedge[c] = r_pos;
    assign negativeedge[c] = r_neg;
    assign edge_seen[c]    = r_seen;
  end

  assign any_edge = |edge_seen;

endmodule

// File: doc/multi_input_conditioner.md
# multi_input_conditioner

Parametrised, multi-channel successor to the single-pin input conditioner. Each channel synchronises an asynchronous pin, debounces it with a configurable stability window, and produces one-cycle rising and falling edge pulses. A shared sticky edge-capture register with a per-channel mask and a synchronous clear lets downstream logic poll or interrupt on button and switch activity. The block sits between board-level pins and the core's control logic; all outputs are in the `clk` domain.

## Interface
- `CHANNELS`, default 4: number of independent input channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flop depth per channel (≥2).
- `WAIT_CYCLES`, default 3: consecutive synchronised cycles a new level must hold before it is accepted (≥1; 1 = no debounce).
- `clk`  in  1: system clock (50 MHz nominal); all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `noisysignal`  in  CHANNELS: raw asynchronous pins.
- `edge_mask`  in  CHANNELS: 1 = channel may set its `edge_seen` bit.
- `clear_seen`  in  CHANNELS: synchronous per-bit clear of `edge_seen`.
- `conditioned`  out  CHANNELS: debounced, synchronised level.
- `positiveedge`  out  CHANNELS: one-cycle pulse when `conditioned` goes 0→1.
- `negativeedge`  out  CHANNELS: one-cycle pulse when `conditioned` goes 1→0.
- `edge_seen`  out  CHANNELS: sticky record of unmasked edges.
- `any_edge`  out  1: OR-reduction of `edge_seen`.

## Operation
- Reset (`reset_n`=0, asynchronous): all synchroniser flops, debounce counters, `conditioned`, `positiveedge`, `negativeedge`, `edge_seen`, `any_edge` forced to 0 immediately; held while low.
- Synchroniser: chain `s[0..SYNC_STAGES-1]`; `s[0]` samples the pin, and `s[last]` feeds the debouncer. Nothing else reads `s[0]`.
- Debouncer, per channel: counter width `$clog2(WAIT_CYCLES+1)`.
  - `s[last] == conditioned`: counter ← 0, no edge.
  - Mismatch and counter < WAIT_CYCLES-1: counter ← counter+1.
  - Mismatch and counter == WAIT_CYCLES-1: `conditioned` ← `s[last]`, counter ← 0, matching edge output ← 1 for this cycle only.
  - Any single cycle of agreement restarts the count; shorter glitches never reach `conditioned`.
- Edge outputs are registered, asserted in the same cycle `conditioned` changes, and deasserted the next cycle. `positiveedge` and `negativeedge` are never both high on one channel.
- Sticky capture per bit: set if (pos|neg edge) & `edge_mask`; else clear if `clear_seen`; else hold. Set wins over a simultaneous clear. `any_edge` is combinational OR of `edge_seen`.
- Channels are fully independent; simultaneous events on different channels are all captured.

## Timing
- Latency: counting the first rising edge that samples a new stable pin level as edge 1, `conditioned` and the edge pulse change after edge SYNC_STAGES+WAIT_CYCLES (defaults: edge 5, 100 time units at 20-unit period).
- Rejection: a pin pulse that is seen by fewer than WAIT_CYCLES consecutive `s[last]` samples produces no output change and no edge.
- Pin change coincident with a clock edge: may be sampled that edge or the next; latency varies by ±1 cycle, with no other effect.
- `edge_seen` updates one edge after the edge pulse; `any_edge` follows it combinationally.
- `clear_seen` takes effect on the next rising edge.
- Reset released with pin held high: `conditioned` rises SYNC_STAGES+WAIT_CYCLES edges after the first edge after release, with one `positiveedge` pulse.
- Reset asserted mid-count: count discarded; no edge pulse is emitted for the interrupted transition.

## Test plan
- Sync/latency, defaults: reset, ch0 pin 0→1 9 units before an edge and held → `conditioned[0]`=1 and `positiveedge[0]` high exactly one cycle after edge 5; falling edge symmetric with `negativeedge[0]`.
- Debounce reject: ch1 pin high for 20 units (one sample), then 40 units (two samples) → `conditioned[1]`, `positiveedge[1]`, `edge_seen[1]` stay 0 for 200 units; a 60-unit high (three samples) is accepted.
- Chatter: ch2 toggles every 10 units for 200 units, then holds 1 → exactly one `positiveedge[2]` pulse, 5 edges after the final settling sample.
- Sticky/mask: `edge_mask`=4'b0101, rise all four pins → `edge_seen`=4'b0101, `any_edge`=1; `clear_seen`=4'b0001 in the same cycle as a new ch0 edge → bit 0 stays 1; a later clear with no edge → 4'b0100.
- Reset mid-operation: pin high, `reset_n` low after edge 3 → outputs 0 immediately, no pulse; release → `positiveedge` fires 5 edges after the first edge after release.
- Parameter sweep: CHANNELS=1, SYNC_STAGES=3, WAIT_CYCLES=1 → latency is 4 edges, and a one-sample glitch propagates as one pulse per transition.
